// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal pixel source: lane states, escape limit, colour packing
// and default frame geometry.
package fractal_pkg;

   typedef enum logic [1:0] {
      LaneIdle = 2'd0,
      LaneIter = 2'd1,
      LaneDone = 2'd2
   } lane_state_e;

   localparam int unsigned DEF_X_SIZE = 640;
   localparam int unsigned DEF_Y_SIZE = 480;
   localparam int unsigned ESCAPE_MAG = 4;

   // |z|^2 threshold expressed in the fixed-point scale of the iteration.
   function automatic int unsigned escape_limit(input int unsigned frac_w);
      return ESCAPE_MAG << frac_w;
   endfunction

   // Only the low byte of each product is kept, so an 8-bit count is sufficient.
   function automatic logic [23:0] pack_rgb(input logic       black,
                                            input logic [7:0] cnt,
                                            input logic [7:0] gain_g,
                                            input logic [7:0] gain_b);
      logic [15:0] g_prod;
      logic [15:0] b_prod;
      g_prod = 16'(cnt) * 16'(gain_g);
      b_prod = 16'(cnt) * 16'(gain_b);
      if (black) begin
         return 24'h000000;
      end
      return {cnt, g_prod[7:0], b_prod[7:0]};
   endfunction

endpackage

// File: rtl/fractal_lane.sv
// One fixed-point escape-time iteration engine with a start/done/ack handshake.
// Per-pixel parameters are latched at start so frame boundaries never disturb in-flight work.
module fractal_lane
   import fractal_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FRAC_W = 8,
   parameter int unsigned ITER_W = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic signed [DATA_W-1:0] i_z0_re,
   input  logic signed [DATA_W-1:0] i_z0_im,
   input  logic signed [DATA_W-1:0] i_add_re,
   input  logic signed [DATA_W-1:0] i_add_im,
   input  logic        [ITER_W-1:0] i_max_iter,
   input  logic        [7:0]        i_gain_g,
   input  logic        [7:0]        i_gain_b,
   input  logic                     i_ack,
   output lane_state_e              o_state,
   output logic        [23:0]       o_rgb
);

   localparam int unsigned P_W = 2 * DATA_W;
   localparam logic signed [P_W:0] LIMIT = (P_W + 1)'(escape_limit(FRAC_W));

   lane_state_e              r_state;
   logic signed [DATA_W-1:0] r_zr;
   logic signed [DATA_W-1:0] r_zi;
   logic signed [DATA_W-1:0] r_add_re;
   logic signed [DATA_W-1:0] r_add_im;
   logic        [ITER_W-1:0] r_count;
   logic        [ITER_W-1:0] r_max;
   logic        [7:0]        r_gain_g;
   logic        [7:0]        r_gain_b;
   logic        [23:0]       r_rgb;

   logic signed [P_W-1:0]    w_zr_ext;
   logic signed [P_W-1:0]    w_zi_ext;
   logic signed [P_W-1:0]    w_zr2;
   logic signed [P_W-1:0]    w_zi2;
   logic signed [P_W:0]      w_mag;
   logic signed [DATA_W-1:0] w_cross;
   logic signed [DATA_W-1:0] w_nzr;
   logic signed [DATA_W-1:0] w_nzi;
   logic                     w_hit_max;
   logic                     w_escape;
   logic        [7:0]        w_cnt8;

   assign w_zr_ext  = P_W'(r_zr);
   assign w_zi_ext  = P_W'(r_zi);
   assign w_zr2     = (w_zr_ext * w_zr_ext) >>> FRAC_W;
   assign w_zi2     = (w_zi_ext * w_zi_ext) >>> FRAC_W;
   assign w_mag     = (P_W + 1)'(w_zr2) + (P_W + 1)'(w_zi2);
   assign w_cross   = DATA_W'(((w_zr_ext * w_zi_ext) <<< 1) >>> FRAC_W);
   // Next-z arithmetic deliberately wraps at DATA_W.
   assign w_nzr     = w_zr2[DATA_W-1:0] - w_zi2[DATA_W-1:0] + r_add_re;
   assign w_nzi     = w_cross + r_add_im;
   assign w_hit_max = (r_count == r_max);
   assign w_escape  = (w_mag > LIMIT);

   if (ITER_W >= 8) begin : g_cnt_wide
      assign w_cnt8 = r_count[7:0];
   end else begin : g_cnt_narrow
      assign w_cnt8 = {{(8 - ITER_W){1'b0}}, r_count};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= LaneIdle;
         r_zr     <= '0;
         r_zi     <= '0;
         r_add_re <= '0;
         r_add_im <= '0;
         r_count  <= '0;
         r_max    <= '0;
         r_gain_g <= '0;
         r_gain_b <= '0;
         r_rgb    <= '0;
      end else begin
         unique case (r_state)
            LaneIdle: begin
               if (i_start) begin
                  r_zr     <= i_z0_re;
                  r_zi     <= i_z0_im;
                  r_add_re <= i_add_re;
                  r_add_im <= i_add_im;
                  r_count  <= '0;
                  r_max    <= i_max_iter;
                  r_gain_g <= i_gain_g;
                  r_gain_b <= i_gain_b;
                  r_state  <= LaneIter;
               end
            end
            LaneIter: begin
               if (w_hit_max || w_escape) begin
                  r_rgb   <= pack_rgb(w_hit_max, w_cnt8, r_gain_g, r_gain_b);
                  r_state <= LaneDone;
               end else begin
                  r_zr    <= w_nzr;
                  r_zi    <= w_nzi;
                  r_count <= r_count + ITER_W'(1);
               end
            end
            LaneDone: begin
               if (i_ack) begin
                  r_state <= LaneIdle;
               end
            end
            default: r_state <= LaneIdle;
         endcase
      end
   end

   assign o_state = r_state;
   assign o_rgb   = r_rgb;

endmodule

// File: rtl/fractal_multilane_gen.sv
// Multi-lane fractal pixel source: raster-order dispatch to LANES engines, in-order collection.
// Define JULIA_MODE_EN to add the Julia mode and its configuration ports.
module fractal_multilane_gen
   import fractal_pkg::*;
#(
   parameter int unsigned LANES  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FRAC_W = 8,
   parameter int unsigned ITER_W = 8,
   parameter int unsigned X_SIZE = DEF_X_SIZE,
   parameter int unsigned Y_SIZE = DEF_Y_SIZE
) (
   input  logic                     out_stream_aclk,
   input  logic                     periph_resetn,
   input  logic signed [DATA_W-1:0] cfg_origin_re,
   input  logic signed [DATA_W-1:0] cfg_origin_im,
   input  logic signed [DATA_W-1:0] cfg_step_re,
   input  logic signed [DATA_W-1:0] cfg_step_im,
   input  logic        [ITER_W-1:0] cfg_max_iter,
   input  logic        [7:0]        cfg_gain_g,
   input  logic        [7:0]        cfg_gain_b,
`ifdef JULIA_MODE_EN
   input  logic                     cfg_mode,
   input  logic signed [DATA_W-1:0] cfg_julia_re,
   input  logic signed [DATA_W-1:0] cfg_julia_im,
`endif
   output logic        [23:0]       pix_data,
   output logic                     pix_valid,
   input  logic                     pix_ready,
   output logic                     pix_sof,
   output logic                     pix_eol,
   output logic                     busy
);

   localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned X_W   = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int unsigned Y_W   = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

   logic        [X_W-1:0]    r_x;
   logic        [Y_W-1:0]    r_y;
   logic        [PTR_W-1:0]  r_disp_ptr;
   logic        [PTR_W-1:0]  r_coll_ptr;
   logic signed [DATA_W-1:0] r_c_re;
   logic signed [DATA_W-1:0] r_c_im;
   logic signed [DATA_W-1:0] r_sh_origin_re;
   logic signed [DATA_W-1:0] r_sh_origin_im;
   logic signed [DATA_W-1:0] r_sh_step_re;
   logic signed [DATA_W-1:0] r_sh_step_im;
   logic        [ITER_W-1:0] r_sh_max_iter;
   logic        [7:0]        r_sh_gain_g;
   logic        [7:0]        r_sh_gain_b;
   logic        [LANES-1:0]  r_tag_sof;
   logic        [LANES-1:0]  r_tag_eol;
   logic                     r_valid;
   logic                     r_sof;
   logic                     r_eol;
   logic        [23:0]       r_data;

   logic                     w_at_origin;
   logic                     w_eol_now;
   logic                     w_last_line;
   logic signed [DATA_W-1:0] w_origin_re;
   logic signed [DATA_W-1:0] w_origin_im;
   logic signed [DATA_W-1:0] w_step_re;
   logic signed [DATA_W-1:0] w_step_im;
   logic signed [DATA_W-1:0] w_c_re;
   logic signed [DATA_W-1:0] w_c_im;
   logic        [ITER_W-1:0] w_max_iter;
   logic        [7:0]        w_gain_g;
   logic        [7:0]        w_gain_b;
   logic signed [DATA_W-1:0] w_z0_re;
   logic signed [DATA_W-1:0] w_z0_im;
   logic signed [DATA_W-1:0] w_add_re;
   logic signed [DATA_W-1:0] w_add_im;
   logic        [LANES-1:0]  w_lane_idle;
   logic        [LANES-1:0]  w_lane_done;
   logic        [LANES-1:0]  w_start;
   logic        [LANES-1:0]  w_ack;
   logic        [23:0]       w_lane_rgb [LANES];
   logic                     w_disp;
   logic                     w_coll;
   logic                     w_coll_done;
   logic        [23:0]       w_coll_rgb;
   logic                     w_coll_sof;
   logic                     w_coll_eol;
   logic                     w_out_free;

   // Pixel (0,0) takes live cfg values, since the shadows load in the same cycle.
   assign w_at_origin = (r_x == '0) && (r_y == '0);
   assign w_eol_now   = (r_x == X_W'(X_SIZE - 1));
   assign w_last_line = (r_y == Y_W'(Y_SIZE - 1));
   assign w_origin_re = w_at_origin ? cfg_origin_re : r_sh_origin_re;
   assign w_origin_im = w_at_origin ? cfg_origin_im : r_sh_origin_im;
   assign w_step_re   = w_at_origin ? cfg_step_re   : r_sh_step_re;
   assign w_step_im   = w_at_origin ? cfg_step_im   : r_sh_step_im;
   assign w_c_re      = w_at_origin ? cfg_origin_re : r_c_re;
   assign w_c_im      = w_at_origin ? cfg_origin_im : r_c_im;
   assign w_max_iter  = w_at_origin ? cfg_max_iter  : r_sh_max_iter;
   assign w_gain_g    = w_at_origin ? cfg_gain_g    : r_sh_gain_g;
   assign w_gain_b    = w_at_origin ? cfg_gain_b    : r_sh_gain_b;

`ifdef JULIA_MODE_EN
   logic                     r_sh_mode;
   logic signed [DATA_W-1:0] r_sh_julia_re;
   logic signed [DATA_W-1:0] r_sh_julia_im;
   logic                     w_julia;
   logic signed [DATA_W-1:0] w_julia_re;
   logic signed [DATA_W-1:0] w_julia_im;

   always_ff @(posedge out_stream_aclk) begin
      if (!periph_resetn) begin
         r_sh_mode     <= 1'b0;
         r_sh_julia_re <= '0;
         r_sh_julia_im <= '0;
      end else if (w_disp && w_at_origin) begin
         r_sh_mode     <= cfg_mode;
         r_sh_julia_re <= cfg_julia_re;
         r_sh_julia_im <= cfg_julia_im;
      end
   end

   assign w_julia    = w_at_origin ? cfg_mode     : r_sh_mode;
   assign w_julia_re = w_at_origin ? cfg_julia_re : r_sh_julia_re;
   assign w_julia_im = w_at_origin ? cfg_julia_im : r_sh_julia_im;
   assign w_z0_re    = w_julia ? w_c_re     : '0;
   assign w_z0_im    = w_julia ? w_c_im     : '0;
   assign w_add_re   = w_julia ? w_julia_re : w_c_re;
   assign w_add_im   = w_julia ? w_julia_im : w_c_im;
`else
   assign w_z0_re  = '0;
   assign w_z0_im  = '0;
   assign w_add_re = w_c_re;
   assign w_add_im = w_c_im;
`endif

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_state_e w_state;

      fractal_lane #(
         .DATA_W (DATA_W),
         .FRAC_W (FRAC_W),
         .ITER_W (ITER_W)
      ) u_lane (
         .i_clk      (out_stream_aclk),
         .i_rst_n    (periph_resetn),
         .i_start    (w_start[g]),
         .i_z0_re    (w_z0_re),
         .i_z0_im    (w_z0_im),
         .i_add_re   (w_add_re),
         .i_add_im   (w_add_im),
         .i_max_iter (w_max_iter),
         .i_gain_g   (w_gain_g),
         .i_gain_b   (w_gain_b),
         .i_ack      (w_ack[g]),
         .o_state    (w_state),
         .o_rgb      (w_lane_rgb[g])
      );

      assign w_lane_idle[g] = (w_state == LaneIdle);
      assign w_lane_done[g] = (w_state == LaneDone);
   end

   assign w_out_free = !r_valid || pix_ready;

   always_comb begin
      w_disp      = 1'b0;
      w_coll_done = 1'b0;
      w_coll_rgb  = '0;
      w_coll_sof  = 1'b0;
      w_coll_eol  = 1'b0;
      w_start     = '0;
      w_ack       = '0;
      for (int i = 0; i < LANES; i++) begin
         if (r_disp_ptr == PTR_W'(i)) begin
            w_disp     = w_lane_idle[i];
            w_start[i] = w_lane_idle[i];
         end
         if (r_coll_ptr == PTR_W'(i)) begin
            w_coll_done = w_lane_done[i];
            w_coll_rgb  = w_lane_rgb[i];
            w_coll_sof  = r_tag_sof[i];
            w_coll_eol  = r_tag_eol[i];
            w_ack[i]    = w_lane_done[i] && w_out_free;
         end
      end
   end

   assign w_coll = w_coll_done && w_out_free;

   always_ff @(posedge out_stream_aclk) begin
      if (!periph_resetn) begin
         r_x            <= '0;
         r_y            <= '0;
         r_disp_ptr     <= '0;
         r_coll_ptr     <= '0;
         r_c_re         <= '0;
         r_c_im         <= '0;
         r_sh_origin_re <= '0;
         r_sh_origin_im <= '0;
         r_sh_step_re   <= '0;
         r_sh_step_im   <= '0;
         r_sh_max_iter  <= '0;
         r_sh_gain_g    <= '0;
         r_sh_gain_b    <= '0;
         r_tag_sof      <= '0;
         r_tag_eol      <= '0;
         r_valid        <= 1'b0;
         r_sof          <= 1'b0;
         r_eol          <= 1'b0;
         r_data         <= '0;
      end else begin
         if (w_disp) begin
            for (int i = 0; i < LANES; i++) begin
               if (r_disp_ptr == PTR_W'(i)) begin
                  r_tag_sof[i] <= w_at_origin;
                  r_tag_eol[i] <= w_eol_now;
               end
            end
            if (w_at_origin) begin
               r_sh_origin_re <= cfg_origin_re;
               r_sh_origin_im <= cfg_origin_im;
               r_sh_step_re   <= cfg_step_re;
               r_sh_step_im   <= cfg_step_im;
               r_sh_max_iter  <= cfg_max_iter;
               r_sh_gain_g    <= cfg_gain_g;
               r_sh_gain_b    <= cfg_gain_b;
            end
            r_disp_ptr <= (r_disp_ptr == PTR_W'(LANES - 1)) ? '0 : r_disp_ptr + PTR_W'(1);
            if (w_eol_now) begin
               r_x    <= '0;
               r_c_re <= w_origin_re;
               if (w_last_line) begin
                  r_y    <= '0;
                  r_c_im <= w_origin_im;
               end else begin
                  r_y    <= r_y + Y_W'(1);
                  r_c_im <= w_c_im + w_step_im;
               end
            end else begin
               r_x    <= r_x + X_W'(1);
               r_c_re <= w_c_re + w_step_re;
               r_c_im <= w_c_im;
            end
         end

         if (w_coll) begin
            r_valid    <= 1'b1;
            r_data     <= w_coll_rgb;
            r_sof      <= w_coll_sof;
            r_eol      <= w_coll_eol;
            r_coll_ptr <= (r_coll_ptr == PTR_W'(LANES - 1)) ? '0 : r_coll_ptr + PTR_W'(1);
         end else if (pix_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign pix_valid = r_valid;
   assign pix_data  = r_data;
   assign pix_sof   = r_sof;
   assign pix_eol   = r_eol;
   assign busy      = !(&w_lane_idle) || r_valid;

endmodule

// File: tb/tb_fractal_multilane_gen.sv
// Directed bench: a 4x2 frame rendered by a 1-lane and a 4-lane instance side by side.
module tb_fractal_multilane_gen;

   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic                 ready;
   logic signed [DW-1:0] origin_re, origin_im, step_re, step_im;
   logic        [7:0]    max_iter, gain_g, gain_b;
`ifdef JULIA_MODE_EN
   logic                 mode;
   logic signed [DW-1:0] julia_re, julia_im;
`endif

   logic [23:0] d1, d4;
   logic        v1, v4, s1, s4, e1, e4, b1, b4;

   logic [25:0] q1[$];
   logic [25:0] q4[$];
   logic [25:0] exp_f1 [8];
   logic [25:0] exp_f2 [8];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   fractal_multilane_gen #(
      .LANES (1), .DATA_W (DW), .FRAC_W (8), .ITER_W (8), .X_SIZE (4), .Y_SIZE (2)
   ) u_dut1 (
      .out_stream_aclk (clk),
      .periph_resetn   (rst_n),
      .cfg_origin_re   (origin_re),
      .cfg_origin_im   (origin_im),
      .cfg_step_re     (step_re),
      .cfg_step_im     (step_im),
      .cfg_max_iter    (max_iter),
      .cfg_gain_g      (gain_g),
      .cfg_gain_b      (gain_b),
`ifdef JULIA_MODE_EN
      .cfg_mode        (mode),
      .cfg_julia_re    (julia_re),
      .cfg_julia_im    (julia_im),
`endif
      .pix_data        (d1),
      .pix_valid       (v1),
      .pix_ready       (ready),
      .pix_sof         (s1),
      .pix_eol         (e1),
      .busy            (b1)
   );

   fractal_multilane_gen #(
      .LANES (4), .DATA_W (DW), .FRAC_W (8), .ITER_W (8), .X_SIZE (4), .Y_SIZE (2)
   ) u_dut4 (
      .out_stream_aclk (clk),
      .periph_resetn   (rst_n),
      .cfg_origin_re   (origin_re),
      .cfg_origin_im   (origin_im),
      .cfg_step_re     (step_re),
      .cfg_step_im     (step_im),
      .cfg_max_iter    (max_iter),
      .cfg_gain_g      (gain_g),
      .cfg_gain_b      (gain_b),
`ifdef JULIA_MODE_EN
      .cfg_mode        (mode),
      .cfg_julia_re    (julia_re),
      .cfg_julia_im    (julia_im),
`endif
      .pix_data        (d4),
      .pix_valid       (v4),
      .pix_ready       (ready),
      .pix_sof         (s4),
      .pix_eol         (e4),
      .busy            (b4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic wait_both(input int n, input int budget, input string tag);
      int cyc = 0;
      while ((q1.size() < n || q4.size() < n) && cyc < budget) begin
         @(posedge clk);
         cyc++;
      end
      if (q1.size() < n) chk({tag, "_dut1"}, 32'(q1.size()), 32'(n));
      if (q4.size() < n) chk({tag, "_dut4"}, 32'(q4.size()), 32'(n));
   endtask

   // Transfers are recorded at the negedge before the accepting posedge.
   always @(negedge clk) begin
      if (rst_n && ready) begin
         if (v1) q1.push_back({s1, e1, d1});
         if (v4) q4.push_back({s4, e4, d4});
      end
   end

   initial begin
      int cyc;
      // {sof, eol, rgb}; c = (-2..1, -1..0), max_iter 16, gains 1/1
      exp_f1 = '{26'h2010101, 26'h0030303, 26'h0000000, 26'h1020202,
                 26'h0000000, 26'h0000000, 26'h0000000, 26'h1030303};
      // max_iter 2, gains 3/5: only c=(-2,-1) escapes before the cap
      exp_f2 = '{26'h2010305, 26'h0000000, 26'h0000000, 26'h1000000,
                 26'h0000000, 26'h0000000, 26'h0000000, 26'h1000000};

      rst_n     = 1'b0;
      ready     = 1'b0;
      origin_re = -32'sd512;
      origin_im = -32'sd256;
      step_re   = 32'sd256;
      step_im   = 32'sd256;
      max_iter  = 8'd16;
      gain_g    = 8'd1;
      gain_b    = 8'd1;
`ifdef JULIA_MODE_EN
      mode      = 1'b0;
      julia_re  = '0;
      julia_im  = '0;
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid1", v1, 0);
      chk("rst_data1", d1, 0);
      chk("rst_sideband1", {s1, e1}, 0);
      chk("rst_busy1", b1, 0);
      chk("rst_valid4", v4, 0);
      chk("rst_data4", d4, 0);
      chk("rst_sideband4", {s4, e4}, 0);
      chk("rst_busy4", b4, 0);

      rst_n = 1'b1;
      cyc = 0;
      while (!v4 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!v4) chk("first_valid4", v4, 1);

      // Mid-frame change: must only take effect on the next frame.
      max_iter = 8'd2;
      gain_g   = 8'd3;
      gain_b   = 8'd5;

      repeat (30) @(posedge clk);
      #1;
      chk("stall_valid4", v4, 1);
      chk("stall_data4", d4, 24'h010101);
      chk("stall_sideband4", {s4, e4}, 2'b10);
      chk("stall_busy4", b4, 1);
      chk("stall_lanes4", u_dut4.w_lane_done, 4'hF);
      chk("stall_valid1", v1, 1);
      chk("stall_data1", d1, 24'h010101);
      chk("stall_sideband1", {s1, e1}, 2'b10);
      chk("stall_lanes1", u_dut1.w_lane_done, 1'b1);

      ready = 1'b1;
      wait_both(16, 3000, "timeout_f12");
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("f1_dut1_px%0d", i), q1[i], exp_f1[i]);
         chk($sformatf("f1_dut4_px%0d", i), q4[i], exp_f1[i]);
         chk($sformatf("f2_dut1_px%0d", i), q1[i + 8], exp_f2[i]);
         chk($sformatf("f2_dut4_px%0d", i), q4[i + 8], exp_f2[i]);
      end

      // One-cycle reset mid-stream, then a max_iter==0 frame.
      max_iter = 8'd0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("mid_rst_valid1", v1, 0);
      chk("mid_rst_valid4", v4, 0);
      chk("mid_rst_data4", d4, 0);
      chk("mid_rst_busy4", b4, 0);
      q1.delete();
      q4.delete();
      wait_both(8, 1000, "timeout_f3");
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("f3_dut1_px%0d", i), q1[i], {exp_f1[i][25:24], 24'h000000});
         chk($sformatf("f3_dut4_px%0d", i), q4[i], {exp_f1[i][25:24], 24'h000000});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
